// File: rtl/dmem_pkg.sv
// Shared types, byte-enable constants and the byte-enable legality helper for the
// data-memory responder. The helper is only called when DMEM_CHECK_EN is defined.
package dmem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dmem_state_t;

    localparam logic [3:0] WEA_NONE = 4'b0000;
    localparam logic [3:0] WEA_B0   = 4'b0001;
    localparam logic [3:0] WEA_B1   = 4'b0010;
    localparam logic [3:0] WEA_B2   = 4'b0100;
    localparam logic [3:0] WEA_B3   = 4'b1000;
    localparam logic [3:0] WEA_H0   = 4'b0011;
    localparam logic [3:0] WEA_H1   = 4'b1100;
    localparam logic [3:0] WEA_W    = 4'b1111;

    // A write pattern must be a byte, half or word that starts at the byte offset.
    function automatic logic wea_legal(input logic [3:0] wea, input logic [1:0] off);
        logic ok;
        case (wea)
            WEA_NONE: ok = 1'b1;
            WEA_B0:   ok = (off == 2'd0);
            WEA_B1:   ok = (off == 2'd1);
            WEA_B2:   ok = (off == 2'd2);
            WEA_B3:   ok = (off == 2'd3);
            WEA_H0:   ok = (off == 2'd0);
            WEA_H1:   ok = (off == 2'd2);
            WEA_W:    ok = (off == 2'd0);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// CPU data-SRAM port bundle. The misalign flag exists only when DMEM_CHECK_EN is defined;
// fsm_state is a debug view of the responder's wait-state FSM.
interface dmem_if;
    import dmem_pkg::*;

    // Handshake: the CPU raises en with addr/wea/wdata and must hold all of them stable
    // while stall is high; the access commits on the first rising edge where en=1 and
    // stall=0, and read data appears on rdata after that edge.
    logic        en;
    logic [3:0]  wea;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    dmem_state_t fsm_state;
`ifdef DMEM_CHECK_EN
    logic        misalign;

    modport master (output en, wea, addr, wdata, input rdata, stall, fsm_state, misalign);
    modport slave  (input en, wea, addr, wdata, output rdata, stall, fsm_state, misalign);
`else
    modport master (output en, wea, addr, wdata, input rdata, stall, fsm_state);
    modport slave  (input en, wea, addr, wdata, output rdata, stall, fsm_state);
`endif

endinterface

// File: rtl/dmem_byte_ram.sv
// Four byte-wide storage banks with per-lane synchronous write and a registered,
// resettable read word. Storage itself is never reset.
module dmem_byte_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] word,
    input  logic [31:0]           wdata,
    input  logic                  rd_en,
    output logic [31:0]           rdata
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] bank [0:(1 << ADDR_WIDTH) - 1];
        logic [7:0] q;

        always_ff @(posedge clk) begin
            if (we[i]) begin
                bank[word] <= wdata[8*i +: 8];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q <= 8'h00;
            end else if (rd_en) begin
                q <= bank[word];
            end
        end

        assign rdata[8*i +: 8] = q;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-SRAM responder with programmable wait states and stall output.
// Define DMEM_CHECK_EN to suppress illegal/misaligned writes and raise misalign.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t           state;
    dmem_state_t           state_next;
    logic [3:0]            cnt;
    logic [3:0]            cnt_next;
    logic                  commit;
    logic                  stall;
    logic                  access;
    logic                  is_write;
    logic                  wr_ok;
    logic [3:0]            we;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] word;
    logic                  unused_addr;

    assign word        = bus.addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // With zero wait states the FSM never leaves IDLE and every en cycle commits.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        stall      = 1'b0;
        if (WAIT_CYCLES == 0) begin
            commit = bus.en;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                        stall      = 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt_next = cnt - 4'd1;
                        stall    = bus.en;
                    end else begin
                        // Completes even if en was dropped mid-request.
                        commit     = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // A reset edge never commits, so a request caught in WAIT writes nothing.
    assign access   = commit & ~rst;
    assign is_write = |bus.wea;

`ifdef DMEM_CHECK_EN
    logic misalign;

    assign wr_ok = wea_legal(bus.wea, bus.addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= access & is_write & ~wr_ok;
        end
    end

    assign bus.misalign = misalign;
`else
    assign wr_ok = 1'b1;
`endif

    assign we    = (access && wr_ok) ? bus.wea : 4'b0000;
    assign rd_en = access & ~is_write;

    dmem_byte_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .word  (word),
        .wdata (bus.wdata),
        .rd_en (rd_en),
        .rdata (bus.rdata)
    );

    assign bus.stall     = stall;
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a zero-wait instance and a 3-wait-state instance, each with
// a word model and a read-data expected queue. Define DMEM_CHECK_EN to cover the checker.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_fast;
    logic rst_slow;

    dmem_if f_bus ();
    dmem_if s_bus ();

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_fast (
        .clk (clk),
        .rst (rst_fast),
        .bus (f_bus)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_slow (
        .clk (clk),
        .rst (rst_slow),
        .bus (s_bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q_fast[$];
    logic [31:0] exp_q_slow[$];
    logic [31:0] model_fast [1024];
    logic [31:0] model_slow [1024];
    logic        fast_fire = 1'b0;
    logic        slow_fire = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] wea);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (wea[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // Legal = a contiguous run of 1, 2 or 4 lanes, size-aligned, starting at the offset.
    function automatic logic wr_legal(input logic [3:0] wea, input logic [1:0] off);
`ifdef DMEM_CHECK_EN
        logic [7:0] m;
        int sizes [3] = '{1, 2, 4};
        if (wea == 4'b0000) return 1'b1;
        for (int k = 0; k < 3; k++) begin
            m = 8'(((1 << sizes[k]) - 1) << off);
            if ((int'(off) % sizes[k]) == 0 && m[7:4] == 4'b0000 && m[3:0] == wea) return 1'b1;
        end
        return 1'b0;
`else
        return (wea == wea) | (off == off);
`endif
    endfunction

    // ---------------- monitor: a read commits where en=1, stall=0 at the rising edge ----------------
    always @(posedge clk) begin
        fast_fire = f_bus.en && !f_bus.stall && (f_bus.wea == 4'b0000) && !rst_fast;
        slow_fire = s_bus.en && !s_bus.stall && (s_bus.wea == 4'b0000) && !rst_slow;
    end

    always @(negedge clk) begin
        if (fast_fire) begin
            if (exp_q_fast.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL fast_unexpected_read: got %h expected none", f_bus.rdata);
            end else begin
                check("fast_rdata", f_bus.rdata, exp_q_fast.pop_front());
            end
        end
        if (slow_fire) begin
            if (exp_q_slow.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL slow_unexpected_read: got %h expected none", s_bus.rdata);
            end else begin
                check("slow_rdata", s_bus.rdata, exp_q_slow.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fast_op(input logic [3:0] wea, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        f_bus.en    = 1'b1;
        f_bus.wea   = wea;
        f_bus.addr  = a;
        f_bus.wdata = d;
        if (wea == 4'b0000) begin
            exp_q_fast.push_back(model_fast[widx(a)]);
        end else if (wr_legal(wea, a[1:0])) begin
            model_fast[widx(a)] = merge(model_fast[widx(a)], d, wea);
        end
        #1 check("fast_stall", 32'(f_bus.stall), 32'd0);
    endtask

    task automatic fast_idle();
        @(negedge clk);
        f_bus.en  = 1'b0;
        f_bus.wea = 4'b0000;
    endtask

    task automatic slow_op(input logic [3:0] wea, input logic [31:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        s_bus.en    = 1'b1;
        s_bus.wea   = wea;
        s_bus.addr  = a;
        s_bus.wdata = d;
        if (wea == 4'b0000) begin
            exp_q_slow.push_back(model_slow[widx(a)]);
        end else if (wr_legal(wea, a[1:0])) begin
            model_slow[widx(a)] = merge(model_slow[widx(a)], d, wea);
        end
        n = 0;
        #1;
        while (s_bus.stall === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("slow_stall_cycles", 32'(n), 32'd3);
    endtask

    task automatic slow_idle();
        @(negedge clk);
        s_bus.en  = 1'b0;
        s_bus.wea = 4'b0000;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [31:0] a;
        logic [3:0]  w;

        for (int i = 0; i < 1024; i++) begin
            model_fast[i] = 32'h0;
            model_slow[i] = 32'h0;
        end
        f_bus.en = 1'b0; f_bus.wea = 4'b0; f_bus.addr = 32'h0; f_bus.wdata = 32'h0;
        s_bus.en = 1'b0; s_bus.wea = 4'b0; s_bus.addr = 32'h0; s_bus.wdata = 32'h0;
        rst_fast = 1'b1;
        rst_slow = 1'b1;
        repeat (2) @(negedge clk);
        rst_fast = 1'b0;
        rst_slow = 1'b0;
        #1;
        check("rst_fast_rdata", f_bus.rdata, 32'h0);
        check("rst_slow_rdata", s_bus.rdata, 32'h0);
        check("rst_slow_stall", 32'(s_bus.stall), 32'd0);
        check("rst_slow_state", 32'(s_bus.fsm_state), 32'(IDLE));
`ifdef DMEM_CHECK_EN
        check("rst_fast_misalign", 32'(f_bus.misalign), 32'd0);
`endif

        // zero-wait: store word, load word, then rdata holds across idle and a write
        fast_op(4'b1111, 32'h10, 32'h12345678);
        fast_op(4'b0000, 32'h10, 32'h0);
        fast_idle();
        #1 check("fast_lw_1", f_bus.rdata, 32'h12345678);
        fast_op(4'b1111, 32'h40, 32'hDEADBEEF);
        fast_idle();
        #1 check("fast_rdata_hold", f_bus.rdata, 32'h12345678);

        // byte store into lane 2 of the same word
        fast_op(4'b0100, 32'h12, 32'h00AB0000);
        fast_op(4'b0000, 32'h10, 32'h0);
        fast_idle();
        #1 check("fast_sb_merge", f_bus.rdata, 32'h12AB5678);

        // back-to-back accesses every cycle
        fast_op(4'b1111, 32'h80, 32'hA5A5A5A5);
        fast_op(4'b1111, 32'h84, 32'h5A5A5A5A);
        fast_op(4'b0000, 32'h80, 32'h0);
        fast_op(4'b0000, 32'h84, 32'h0);
        fast_op(4'b0011, 32'h80, 32'h00001234);
        fast_op(4'b0000, 32'h80, 32'h0);
        fast_idle();

        // random byte/half/word stores over a small window, then read every word back
        for (int i = 0; i < 8; i++) fast_op(4'b1111, 32'(32'h100 + i * 4), 32'h0);
        for (int i = 0; i < 24; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 31));
            w = 4'($urandom_range(1, 15));
            fast_op(w, a, $urandom());
            if ($urandom_range(0, 3) == 0) fast_idle();
        end
        for (int i = 0; i < 8; i++) fast_op(4'b0000, 32'(32'h100 + i * 4), 32'h0);
        fast_idle();

        // upper address bits alias onto the same word
        fast_op(4'b1111, 32'h1000, 32'hCAFEF00D);
        fast_op(4'b0000, 32'h0000, 32'h0);
        fast_idle();
        #1 check("fast_alias", f_bus.rdata, 32'hCAFEF00D);

`ifdef DMEM_CHECK_EN
        fast_op(4'b1111, 32'h10, 32'h11223344);
        fast_op(4'b0110, 32'h11, 32'hFFFFFFFF);
        fast_idle();
        #1 check("misalign_pulse", 32'(f_bus.misalign), 32'd1);
        fast_idle();
        #1 check("misalign_clear", 32'(f_bus.misalign), 32'd0);
        fast_op(4'b0000, 32'h10, 32'h0);
        fast_idle();
        #1 check("misalign_unchanged", f_bus.rdata, 32'h11223344);
        fast_op(4'b1100, 32'h12, 32'hAABB0000);
        fast_idle();
        #1 check("sh_legal_no_flag", 32'(f_bus.misalign), 32'd0);
        fast_op(4'b0000, 32'h10, 32'h0);
        fast_idle();
        #1 check("sh_legal_written", f_bus.rdata, 32'hAABB3344);
        fast_op(4'b0000, 32'h13, 32'h0);
        fast_idle();
        #1 check("read_never_flagged", 32'(f_bus.misalign), 32'd0);
`endif

        // wait-state instance: basic store/load traffic
        slow_op(4'b1111, 32'h10, 32'h12345678);
        slow_op(4'b1111, 32'h20, 32'h00000000);
        slow_op(4'b0000, 32'h20, 32'h0);
        slow_op(4'b1111, 32'h30, 32'h11111111);
        slow_op(4'b0011, 32'h30, 32'h0000BEEF);
        slow_op(4'b0000, 32'h30, 32'h0);
        slow_idle();
        #1 check("slow_sh_merge", s_bus.rdata, 32'h1111BEEF);

        // held load: stall 1,1,1,0, rdata only after the 4th edge
        @(negedge clk);
        s_bus.en   = 1'b1;
        s_bus.wea  = 4'b0000;
        s_bus.addr = 32'h10;
        exp_q_slow.push_back(model_slow[widx(32'h10)]);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("slow_stall_seq", 32'(s_bus.stall), (k < 3) ? 32'd1 : 32'd0);
            check("slow_rdata_before", s_bus.rdata, 32'h1111BEEF);
            if (k == 1) check("slow_state_wait", 32'(s_bus.fsm_state), 32'(WAIT));
            if (k < 3) @(negedge clk);
        end
        @(negedge clk);
        #1;
        check("slow_lw_done", s_bus.rdata, 32'h12345678);
        // en still held: this is the mandatory IDLE cycle, which starts a fresh request
        check("slow_idle_gap_stall", 32'(s_bus.stall), 32'd1);
        check("slow_idle_gap_state", 32'(s_bus.fsm_state), 32'(IDLE));
        exp_q_slow.push_back(model_slow[widx(32'h10)]);
        n = 0;
        while (s_bus.stall === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("slow_second_req_stalls", 32'(n), 32'd3);
        slow_idle();

        // reset in WAIT aborts a store
        @(negedge clk);
        s_bus.en    = 1'b1;
        s_bus.wea   = 4'b1111;
        s_bus.addr  = 32'h20;
        s_bus.wdata = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        rst_slow  = 1'b1;
        s_bus.en  = 1'b0;
        s_bus.wea = 4'b0000;
        @(negedge clk);
        rst_slow = 1'b0;
        #1;
        check("slow_rst_rdata", s_bus.rdata, 32'h0);
        check("slow_rst_stall", 32'(s_bus.stall), 32'd0);
        check("slow_rst_state", 32'(s_bus.fsm_state), 32'(IDLE));
        slow_op(4'b0000, 32'h20, 32'h0);
        slow_idle();
        #1 check("slow_abort_no_write", s_bus.rdata, 32'h00000000);

        repeat (3) @(negedge clk);
        check("fast_q_empty", 32'(exp_q_fast.size()), 32'd0);
        check("slow_q_empty", 32'(exp_q_slow.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
